// File: rtl/zl_ts_sync_if.sv
// Byte-stream bundle between the TS source, the sync aligner and the DVB-S core.
// Transfers are req/ack: a byte moves on any cycle where both are high.
interface zl_ts_sync_if;
  logic [7:0] data_in;
  logic       data_in_req;
  logic       data_in_ack;
  logic [7:0] data_out;
  logic       data_out_sop;
  logic       data_out_req;
  logic       data_out_ack;

  // Environment side: feeds raw bytes and consumes aligned bytes.
  modport master (
    output data_in, data_in_req, data_out_ack,
    input  data_in_ack, data_out, data_out_sop, data_out_req
  );

  // Aligner side.
  modport slave (
    input  data_in, data_in_req, data_out_ack,
    output data_in_ack, data_out, data_out_sop, data_out_req
  );
endinterface

// File: rtl/zl_ts_sync.sv
// TS packet sync acquisition (HUNT/VERIFY/LOCK) with one registered output stage, latency 1.
// Backpressure: input is acked only when the output register is empty or being consumed.
module zl_ts_sync #(
  parameter int PKT_LEN  = 188,
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 3
) (
  input  logic           clk,
  input  logic           rst,
  zl_ts_sync_if.slave    ts,
  output logic           locked,
  output logic [7:0]     sync_err_cnt
);

  localparam int         PW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pos, pos_nxt, pos_inc;
  logic [7:0]    good, good_nxt, good_inc;
  logic [7:0]    miss, miss_nxt, miss_inc;

  logic          in_xfer, out_xfer, is_sync, at_sop;
  logic          fwd, fwd_sop, err_inc;
  logic [7:0]    fwd_dat;

  logic [7:0]    out_dat;
  logic          out_sop, out_req;

  assign ts.data_in_ack  = !out_req || ts.data_out_ack;
  assign ts.data_out     = out_dat;
  assign ts.data_out_sop = out_sop;
  assign ts.data_out_req = out_req;

  assign in_xfer  = ts.data_in_req && ts.data_in_ack;
  assign out_xfer = out_req && ts.data_out_ack;
  assign is_sync  = (ts.data_in == SYNC_BYTE);
  assign at_sop   = (pos == '0);

  assign pos_inc  = (pos == PW'(PKT_LEN - 1)) ? '0 : pos + PW'(1);
  assign good_inc = good + 8'd1;
  assign miss_inc = miss + 8'd1;

  assign locked   = (state == LOCK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      pos   <= '0;
      good  <= '0;
      miss  <= '0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      good  <= good_nxt;
      miss  <= miss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    good_nxt  = good;
    miss_nxt  = miss;
    fwd       = 1'b0;
    fwd_sop   = 1'b0;
    fwd_dat   = ts.data_in;
    err_inc   = 1'b0;

    if (in_xfer) begin
      unique case (state)
        HUNT: begin
          if (is_sync) begin
            pos_nxt = pos_inc;
            if (LOCK_CNT <= 1) begin
              state_nxt = LOCK;
              good_nxt  = '0;
              miss_nxt  = '0;
              fwd       = 1'b1;
              fwd_sop   = 1'b1;
            end else begin
              state_nxt = VERIFY;
              good_nxt  = 8'd1;
            end
          end
        end

        VERIFY: begin
          pos_nxt = pos_inc;
          if (at_sop) begin
            if (!is_sync) begin
              // The failing byte is dropped, never reconsidered as a new candidate.
              state_nxt = HUNT;
              pos_nxt   = '0;
              good_nxt  = '0;
            end else if (good_inc >= 8'(LOCK_CNT)) begin
              state_nxt = LOCK;
              good_nxt  = '0;
              miss_nxt  = '0;
              fwd       = 1'b1;
              fwd_sop   = 1'b1;
            end else begin
              good_nxt = good_inc;
            end
          end
        end

        LOCK: begin
          pos_nxt = pos_inc;
          fwd     = 1'b1;
          if (at_sop) begin
            // Downstream always sees a clean sync byte, even when the source corrupted it.
            fwd_sop = 1'b1;
            fwd_dat = SYNC_BYTE;
            if (is_sync) begin
              miss_nxt = '0;
            end else begin
              err_inc  = 1'b1;
              miss_nxt = miss_inc;
              if (miss_inc >= 8'(LOSS_CNT)) begin
                state_nxt = HUNT;
                pos_nxt   = '0;
                good_nxt  = '0;
                miss_nxt  = '0;
                fwd       = 1'b0;
              end
            end
          end
        end

        default: begin
          state_nxt = HUNT;
          pos_nxt   = '0;
          good_nxt  = '0;
          miss_nxt  = '0;
        end
      endcase
    end
  end

  // A forwarded byte implies the register was free or draining this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_dat <= 8'h00;
      out_sop <= 1'b0;
      out_req <= 1'b0;
    end else if (fwd) begin
      out_dat <= fwd_dat;
      out_sop <= fwd_sop;
      out_req <= 1'b1;
    end else if (out_xfer) begin
      out_dat <= 8'h00;
      out_sop <= 1'b0;
      out_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err_cnt <= 8'h00;
    end else if (err_inc && (sync_err_cnt != 8'hFF)) begin
      sync_err_cnt <= sync_err_cnt + 8'd1;
    end
  end

  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_req && !ts.data_out_ack) |=> (out_req && $stable(out_dat) && $stable(out_sop)));

endmodule
